// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency mult/div sequencer that owns the HI/LO pair.
// Define MDU_MADD_EN to enable md_op 7 (signed multiply-accumulate).
module mdu_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MLAT = 4'(MULT_LAT);
    localparam logic [3:0] DLAT = 4'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res_q, res_d;
    logic        wr_q, wr_d;
`ifdef MDU_MADD_EN
    logic        acc_q, acc_d;
`endif

    logic is_mul, is_mulu, is_div, is_divu;
    logic is_mthi, is_mtlo, is_madd, is_long;
    logic take, commit;

    always_comb begin
        is_mul  = (md_op == OP_MULT);
        is_mulu = (md_op == OP_MULTU);
        is_div  = (md_op == OP_DIV);
        is_divu = (md_op == OP_DIVU);
        is_mthi = (md_op == OP_MTHI);
        is_mtlo = (md_op == OP_MTLO);
`ifdef MDU_MADD_EN
        is_madd = (md_op == OP_MADD);
`else
        is_madd = 1'b0;
`endif
        is_long = is_mul | is_mulu | is_div | is_divu | is_madd;
    end

    // cancel wins over any request and over the final commit
    assign take   = (state_q == S_IDLE) && start && !cancel;
    assign commit = (state_q == S_RUN) && !cancel && (cnt_q <= 4'd1);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dvs;
    logic               div_ovf;
    logic [31:0]        quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;

    always_comb begin
        prod_s  = $signed({{32{SrcA[31]}}, SrcA})
                * $signed({{32{SrcB[31]}}, SrcB});
        prod_u  = {32'd0, SrcA} * {32'd0, SrcB};
        // a zero divisor never commits; keep the divider well-defined
        dvs     = (SrcB == 32'd0) ? 32'd1 : SrcB;
        div_ovf = (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else begin
            quo_s = $unsigned($signed(SrcA) / $signed(dvs));
            rem_s = $unsigned($signed(SrcA) % $signed(dvs));
        end
        quo_u = SrcA / dvs;
        rem_u = SrcA % dvs;
    end

    always_comb begin
        res_d = res_q;
        wr_d  = wr_q;
`ifdef MDU_MADD_EN
        acc_d = acc_q;
`endif
        if (take && is_long) begin
            wr_d = 1'b1;
`ifdef MDU_MADD_EN
            acc_d = is_madd;
`endif
            unique case (1'b1)
                is_mul:  res_d = prod_s;
                is_mulu: res_d = prod_u;
                is_div: begin
                    res_d = {rem_s, quo_s};
                    wr_d  = (SrcB != 32'd0);
                end
                is_divu: begin
                    res_d = {rem_u, quo_u};
                    wr_d  = (SrcB != 32'd0);
                end
                default: res_d = prod_s;
            endcase
        end
    end

`ifdef MDU_MADD_EN
    logic [63:0] acc_base;
    assign acc_base = acc_q ? {hi_q, lo_q} : 64'd0;
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (take && is_mthi) hi_d = SrcA;
        if (take && is_mtlo) lo_d = SrcA;
        if (commit && wr_q) begin
`ifdef MDU_MADD_EN
            {hi_d, lo_d} = acc_base + res_q;
`else
            {hi_d, lo_d} = res_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            res_q   <= 64'd0;
            wr_q    <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (take && is_long) begin
                    state_d = S_RUN;
                    cnt_d   = (is_div | is_divu) ? DLAT : MLAT;
                end
            end
            S_RUN: begin
                if (cancel || (cnt_q <= 4'd1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases plus randomized ops
// checked against a plain-arithmetic HI/LO reference model.
module tb_mdu_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
        .SrcA(SrcA), .SrcB(SrcB), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          blen;
        int          op;
        int          id;
    } exp_t;

    exp_t        scb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          txn_id = 0;
    int          seen_id = 0;
    int          busy_cnt = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic check(input string nm, input int id,
                         input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d got=%h expected=%h", nm, id, act, exp);
        end
    endtask

    // reference: HI/LO after the op, and how many cycles busy stays high
    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] nh, output logic [31:0] nl,
                                  output int blen);
        longint      sa, sbv, q;
        logic [63:0] p;
        nh   = hi_m;
        nl   = lo_m;
        blen = 0;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sbv; {nh, nl} = p; blen = ML; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; blen = ML; end
            3'd3: begin
                blen = DL;
                if (b != 0) begin
                    q  = sa / sbv;
                    p  = q;
                    nl = p[31:0];
                    p  = sa - q * sbv;
                    nh = p[31:0];
                end
            end
            3'd4: begin
                blen = DL;
                if (b != 0) begin nl = a / b; nh = a % b; end
            end
            3'd5: nh = a;
            3'd6: nl = a;
`ifdef MDU_MADD_EN
            3'd7: begin p = {hi_m, lo_m} + 64'(sa * sbv); {nh, nl} = p; blen = ML; end
`endif
            default: ;
        endcase
    endfunction

    // monitor: measures busy length and checks HI/LO once a txn settles
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (txn_id != seen_id) begin
                seen_id++;
                if (scb.size() == 0) begin
                    check("sb_underflow", seen_id, 64'd1, 64'd0);
                end else begin
                    e = scb.pop_front();
                    check($sformatf("hi op%0d", e.op), e.id, 64'(hi), 64'(e.hi));
                    check($sformatf("lo op%0d", e.op), e.id, 64'(lo), 64'(e.lo));
                    check($sformatf("busy_cycles op%0d", e.op), e.id,
                          64'(busy_cnt), 64'(e.blen));
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
        end
    end

    // called at a negedge; returns at a negedge with the unit idle
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cancel_cyc,
                         input bit mt_spur, input int rst_cyc,
                         input bit cancel_start);
        exp_t        e;
        logic [31:0] nh, nl;
        int          blen;
        model(op, a, b, nh, nl, blen);
        if (cancel_start) begin
            nh = hi_m; nl = lo_m; blen = 0;
        end else if (blen > 0 && rst_cyc > 0 && rst_cyc < blen) begin
            nh = 32'd0; nl = 32'd0; blen = rst_cyc;
        end else if (blen > 0 && cancel_cyc > 0 && cancel_cyc <= blen) begin
            nh = hi_m; nl = lo_m; blen = cancel_cyc;
        end
        e.hi = nh; e.lo = nl; e.blen = blen; e.op = int'(op); e.id = txn_id + 1;
        scb.push_back(e);
        hi_m = nh;
        lo_m = nl;

        start = 1'b1; md_op = op; SrcA = a; SrcB = b; cancel = cancel_start;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; cancel = 1'b0;
        SrcA = $urandom(); SrcB = $urandom();
        for (int k = 1; k <= 40; k++) begin
            if (!busy) break;
            if (k == cancel_cyc) cancel = 1'b1;
            if (mt_spur && k == 2) begin
                start = 1'b1; md_op = 3'd6; SrcA = $urandom();
            end
            if (k == rst_cyc) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", txn_id + 1, 64'(busy), 64'd0);
                check("rst_hi", txn_id + 1, 64'(hi), 64'd0);
                check("rst_lo", txn_id + 1, 64'(lo), 64'd0);
            end
            @(negedge clk);
            cancel = 1'b0; start = 1'b0; md_op = 3'd0; reset_n = 1'b1;
        end
        check("busy_released", txn_id + 1, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        txn_id++;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          cc, sel;
        bit          cs;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'h1234_5678, 32'h9, 0, 0, 0, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        do_op(3'd4, 32'd7, 32'd0, 0, 0, 0, 0);
        do_op(3'd5, 32'h1234_5678, 32'd0, 0, 0, 0, 0);
        do_op(3'd1, 32'h0001_0003, 32'h0002_0005, 0, 1, 0, 0);
        do_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3, 0, 0, 0);
        do_op(3'd3, 32'd100, 32'd7, DL, 0, 0, 0);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 1);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        do_op(3'd3, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0);
        do_op(3'd4, 32'hFFFF_FFFF, 32'd10, 0, 0, 0, 0);
        do_op(3'd1, 32'h0000_1234, 32'h0000_5678, 0, 0, 2, 0);
        do_op(3'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        do_op(3'd6, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0);
        do_op(3'd5, 32'h0000_0000, 32'd0, 0, 0, 0, 0);
        do_op(3'd7, 32'd1, 32'd1, 0, 0, 0, 0);
        do_op(3'd7, 32'hFFFF_FFFF, 32'd3, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom();
            b   = $urandom();
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 9));
            cc  = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 12) : 0;
            cs  = ($urandom_range(0, 9) == 0);
            do_op(op, a, b, cc, 0, 0, cs);
        end

        for (int w = 0; w < 10 && txn_id != seen_id; w++) @(negedge clk);
        check("sb_drained", 0, 64'(scb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer that sits beside the ALU in the EX stage. It accepts mult/multu/div/divu and mthi/mtlo requests, runs multi-cycle operations with a fixed latency, and owns the HI/LO register pair. It also drives `busy` so hazard logic can stall any instruction that needs the unit or HI/LO.

## Interface
- `MULT_LAT`, default 5: busy cycles for mult/multu (and madd when enabled); legal range 1..15.
- `DIV_LAT`, default 10: busy cycles for div/divu; legal range 1..15.

- `clk` input 1: single clock, all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe, sampled on the rising edge.
- `md_op` input 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (see Configuration).
- `SrcA` input 32: operand A / dividend / mthi-mtlo data.
- `SrcB` input 32: operand B / divisor.
- `cancel` input 1: abort in-flight operation (exception or flush).
- `busy` output 1: unit occupied.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States are IDLE and RUN. A 4-bit down-counter `cnt` runs only in RUN.
- Reset values: state IDLE, `busy`=0, `hi`=0, `lo`=0, `cnt`=0.
- IDLE, `start`=1 with md_op 1–4:
  - Latch the op and both operands.
  - Load `cnt` with the op latency.
  - Go to RUN.
- IDLE, `start`=1 with md_op 5/6:
  - Write `SrcA` into HI or LO on that edge.
  - Stay IDLE; `busy` is never raised.
- `md_op`=0, or `start`=0: no action.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt` reaches 0, commit the result to HI/LO and return to IDLE.
- `start` while in RUN is ignored, for every op including mthi/mtlo. Upstream must stall on `busy`.
- `cancel`=1 at an edge has priority over everything:
  - In RUN: go to IDLE, drop `busy`, HI/LO unchanged.
  - In IDLE: any concurrent `start` (including mthi/mtlo) is discarded.
- Arithmetic rules:
  - mult/multu: 64-bit signed/unsigned product. HI = upper 32 bits, LO = lower 32 bits.
  - div/divu: LO = quotient, HI = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0: the operation still occupies DIV_LAT cycles; HI/LO are left unchanged at commit.
- The result may be computed at start and held in a pending register, or computed iteratively. Only the commit timing below is observable.

## Timing
- `start` of mult/div accepted at edge t0: `busy`=1 from t0 through the cycle ending at edge t0+LAT.
- At edge t0+LAT, HI/LO take the new values and `busy` falls.
- A new `start` is accepted on edge t0+LAT+1 at the earliest. Back-to-back throughput is therefore one op per LAT+1 cycles.
- mthi/mtlo: HI/LO visible the cycle after the accepting edge. Latency 1, no busy.
- `hi`/`lo` are direct register outputs with no combinational bypass. Readers (mfhi/mflo) must stall while `busy`=1.
- `reset_n` low mid-operation: state, `busy`, `hi`, `lo` and `cnt` clear immediately without waiting for a clock. No commit occurs after release.
- `cancel` on the same edge where `cnt` reaches 0: the commit is suppressed.

## Configuration
- `MDU_MADD_EN` defined:
  - md_op 7 = madd, signed.
  - {HI,LO} <= {HI,LO} + SrcA*SrcB, computed in 64-bit two's complement with wrap-around.
  - Latency MULT_LAT.
  - The accumulator operand is HI/LO as sampled at commit.
- `MDU_MADD_EN` undefined:
  - md_op 7 is treated as md_op 0.
  - No state change, `busy` stays 0.
  - No accumulate datapath is synthesized.

## Test plan
- Reset, then mult with SrcA=0xFFFFFFFF, SrcB=2 -> `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with SrcA=-7, SrcB=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/0 -> 10 busy cycles, HI/LO unchanged.
- mthi 0x12345678 while idle -> `hi`=0x12345678 next cycle, `busy` stays 0. mtlo strobed during a running mult -> ignored, and LO ends with the mult result.
- mult started, `cancel` on busy cycle 3 -> `busy` low next cycle, HI/LO unchanged. Repeat with `reset_n` pulsed low mid-run -> all outputs 0 immediately.
- With `MDU_MADD_EN`: HI:LO=0x0:0xFFFFFFFF, madd 1*1 -> HI=1, LO=0 after 5 cycles. Without the macro, md_op 7 -> no busy, no change.
